// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: shared types and op-decode helpers for the RV32M
// multiply/divide execute unit.
package ex_muldiv_unit_pkg;

    // funct3 encoding of the M-extension ops
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } muldiv_state_t;

    // Divide/remainder family lives in the upper half of funct3.
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is treated as signed. MUL is deliberately unsigned: its low half
    // is identical either way, so the cheaper path is used.
    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    // rs2 is treated as signed (MULHSU keeps rs2 unsigned).
    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_step.sv
// ex_div_step: one restoring-division iteration. Shifts the next dividend
// bit out of the quotient register into the partial remainder, tries to
// subtract the divisor, and records the resulting quotient bit.
module ex_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    // Partial remainder is always < divisor, so shifted < 2*divisor and the
    // top bit of the XLEN+1 wide difference is a reliable borrow flag.
    always_comb begin
        shifted = {rem_i, quot_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_i};
        fits    = ~diff[XLEN];
        rem_o   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quot_o  = {quot_i[XLEN-2:0], fits};
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) with valid/ready handshakes and flush.
// Operands are reduced to magnitudes on accept, a 1 bit/cycle shift-add or
// restoring shift-subtract runs for XLEN cycles, then one finalize cycle in
// DONE applies the sign fix and loads the output registers.
// Optional build macro: MULDIV_FAST_MUL_EN -- MUL* become a single-cycle
// combinational multiply (accept goes straight to DONE).
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_src_a,
    input  logic [XLEN-1:0]  in_src_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [1:0] ST_IDLE = MD_IDLE;
    localparam logic [1:0] ST_BUSY = MD_BUSY;
    localparam logic [1:0] ST_DONE = MD_DONE;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    // hi/lo double as product {hi,lo} for multiply and {remainder,quotient}
    // for divide; opb holds the multiplicand or the divisor.
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  opb_q, opb_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic             sign_main_q, sign_main_d;   // product / quotient sign
    logic             sign_rem_q, sign_rem_d;     // remainder sign
    logic             special_q, special_d;       // lo_q already holds final result
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    // Accept-time decode
    logic            accept;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] special_val;

    // Iteration datapath
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] div_rem, div_quot;

    // Finalize datapath
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, final_result;

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign accept     = in_valid & in_ready & ~flush;

    // Operand magnitudes, signs and the two short-circuit divide cases
    always_comb begin
        a_neg       = is_signed_a(in_op) & in_src_a[XLEN-1];
        b_neg       = is_signed_b(in_op) & in_src_b[XLEN-1];
        abs_a       = a_neg ? -in_src_a : in_src_a;
        abs_b       = b_neg ? -in_src_b : in_src_b;
        div_by_zero = is_div(in_op) & (in_src_b == '0);
        div_ovf     = is_div(in_op) & ~in_op[0] & (in_src_a == MIN_NEG) & (in_src_b == '1);
        if (div_by_zero) begin
            special_val = in_op[1] ? in_src_a : '1;
        end else begin
            special_val = in_op[1] ? '0 : in_src_a;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif

    // Shift-add step: add multiplicand on the current multiplier bit, then
    // shift the whole product right, consuming one multiplier bit from lo.
    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : {XLEN{1'b0}})};

    ex_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (hi_q),
        .quot_i    (lo_q),
        .divisor_i (opb_q),
        .rem_o     (div_rem),
        .quot_o    (div_quot)
    );

    // Sign fix of magnitude results and selection of the architectural result
    always_comb begin
        prod_fix = sign_main_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quot_fix = sign_main_q ? -lo_q : lo_q;
        rem_fix  = sign_rem_q ? -hi_q : hi_q;
        if (special_q) begin
            final_result = lo_q;
        end else if (is_div(op_q)) begin
            final_result = op_q[1] ? rem_fix : quot_fix;
        end else if (op_q == MUL) begin
            final_result = prod_fix[XLEN-1:0];
        end else begin
            final_result = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // FSM and datapath next-state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        tag_d        = tag_q;
        opb_d        = opb_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        sign_main_d  = sign_main_q;
        sign_rem_d   = sign_rem_q;
        special_d    = special_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d        = in_op;
                    tag_d       = in_tag;
                    cnt_d       = '0;
                    special_d   = 1'b0;
                    sign_main_d = a_neg ^ b_neg;
                    sign_rem_d  = a_neg;
                    hi_d        = '0;
                    if (is_div(in_op)) begin
                        lo_d  = abs_a;
                        opb_d = abs_b;
                        if (div_by_zero || div_ovf) begin
                            special_d = 1'b1;
                            lo_d      = special_val;
                            state_d   = ST_DONE;
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        {hi_d, lo_d} = fast_prod;
                        state_d      = ST_DONE;
`else
                        lo_d    = abs_b;
                        opb_d   = abs_a;
                        state_d = ST_BUSY;
`endif
                    end
                end
            end
            ST_BUSY: begin
                if (is_div(op_q)) begin
                    hi_d = div_rem;
                    lo_d = div_quot;
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_result_d = final_result;
                    out_tag_d    = tag_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            tag_q        <= '0;
            opb_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            sign_main_q  <= 1'b0;
            sign_rem_q   <= 1'b0;
            special_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            opb_q        <= opb_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            sign_main_q  <= sign_main_d;
            sign_rem_q   <= sign_rem_d;
            special_q    <= special_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

endmodule
